// File: rtl/sat_accum_pkg.sv
// Shared types and helpers for the multi-lane saturating accumulator.
// The optional overflow flag build is selected with SAT_ACCUM_LANES_OVF_FLAG_EN.
package sat_accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [63:0] sum;
    logic               ovf;
  } sat_res_t;

  function automatic int cnt_width(input int maxbeats);
    return $clog2(maxbeats + 1);
  endfunction

  localparam int DEF_MAXBEATS = 256;
  localparam int DEF_CNTW     = cnt_width(DEF_MAXBEATS);

  // Operands arrive sign-extended to 64 bits; an accw-bit accumulator plus a
  // narrower operand cannot overflow 64 bits, so the clamp is exact.
  function automatic sat_res_t sat_add(input logic signed [63:0] acc,
                                       input logic signed [63:0] data,
                                       input int unsigned        accw);
    logic signed [63:0] raw;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           res;
    raw = acc + data;
    hi  = (64'sd1 <<< (accw - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    res.ovf = 1'b0;
    if (raw > hi) begin
      res.sum = hi;
      res.ovf = 1'b1;
    end else if (raw < lo) begin
      res.sum = lo;
      res.ovf = 1'b1;
    end else begin
      res.sum = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_add_lane.sv
// One accumulation lane: running sum, saturating add and registered result.
// With SAT_ACCUM_LANES_OVF_FLAG_EN it also carries a sticky clamp flag.
module sat_add_lane
  import sat_accum_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int ACCW  = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [DATAW-1:0] data_i,
  input  logic            accept_i,
  input  logic            close_i,
  output logic [ACCW-1:0] sum_o
`ifdef SAT_ACCUM_LANES_OVF_FLAG_EN
  ,
  output logic            ovf_o
`endif
);

  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] sum_q;
  logic signed [63:0]     acc_ext;
  logic signed [63:0]     data_ext;
  sat_res_t               res;
  logic [ACCW-1:0]        res_sum;
  logic                   unused_bits;

  assign acc_ext     = {{(64-ACCW){acc_q[ACCW-1]}}, acc_q};
  assign data_ext    = {{(64-DATAW){data_i[DATAW-1]}}, data_i};
  assign res         = sat_add(acc_ext, data_ext, ACCW);
  assign res_sum     = res.sum[ACCW-1:0];
  assign unused_bits = ^{res.sum[63:ACCW], res.ovf};

  // A closing beat publishes the sum and empties the accumulator together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      sum_q <= '0;
    end else if (accept_i) begin
      if (close_i) begin
        acc_q <= '0;
        sum_q <= res_sum;
      end else begin
        acc_q <= res_sum;
      end
    end
  end

  assign sum_o = sum_q;

`ifdef SAT_ACCUM_LANES_OVF_FLAG_EN
  logic sticky_q;
  logic ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept_i) begin
      if (close_i) begin
        sticky_q <= 1'b0;
        ovf_q    <= sticky_q | res.ovf;
      end else begin
        sticky_q <= sticky_q | res.ovf;
      end
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/sat_accum_lanes.sv
// Multi-lane signed saturating accumulator with valid/ready on both sides.
// Define SAT_ACCUM_LANES_OVF_FLAG_EN to add the per-lane ovf_o clamp flags.
module sat_accum_lanes
  import sat_accum_pkg::*;
#(
  parameter int DATAW    = 8,
  parameter int ACCW     = 16,
  parameter int LANES    = 4,
  parameter int MAXBEATS = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [LANES*DATAW-1:0]         data_i,
  input  logic                           valid_i,
  input  logic                           last_i,
  output logic                           ready_o,
  output logic [LANES*ACCW-1:0]          sum_o,
  output logic [$clog2(MAXBEATS+1)-1:0]  beats_o,
  output logic                           valid_o,
  input  logic                           ready_i
`ifdef SAT_ACCUM_LANES_OVF_FLAG_EN
  ,
  output logic [LANES-1:0]               ovf_o
`endif
);

  localparam int CNTW = cnt_width(MAXBEATS);

  if (ACCW < DATAW || ACCW > 63) begin : g_bad_width
    $error("sat_accum_lanes: ACCW must satisfy DATAW <= ACCW <= 63");
  end

  state_t          state_q;
  state_t          state_d;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_inc;
  logic [CNTW-1:0] beats_q;
  logic            valid_q;
  logic            accept;
  logic            close;

  assign ready_o   = !valid_q || ready_i;
  assign accept    = valid_i && ready_o;
  assign count_inc = count_q + 1'b1;
  assign close     = accept && (last_i || (count_inc == CNTW'(MAXBEATS)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !close) state_d = ACCUM;
      ACCUM:   if (close) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (close) count_q <= '0;
      else if (accept) count_q <= count_inc;
    end
  end

  // A new close overrides a same-cycle drain, so results stream with no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      beats_q <= '0;
    end else begin
      if (close) begin
        valid_q <= 1'b1;
        beats_q <= count_inc;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign beats_o = beats_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sat_add_lane #(
      .DATAW(DATAW),
      .ACCW (ACCW)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .data_i  (data_i[k*DATAW +: DATAW]),
      .accept_i(accept),
      .close_i (close),
      .sum_o   (sum_o[k*ACCW +: ACCW])
`ifdef SAT_ACCUM_LANES_OVF_FLAG_EN
      ,
      .ovf_o   (ovf_o[k])
`endif
    );
  end

endmodule

// File: tb/tb_sat_accum_lanes.sv
// Scoreboard bench for sat_accum_lanes: a behavioural model queues expected
// results on accepted closing beats; outputs are compared on the falling edge.
module tb_sat_accum_lanes;

  localparam int DATAW    = 8;
  localparam int ACCW     = 8;
  localparam int LANES    = 4;
  localparam int MAXBEATS = 4;
  localparam int CNTW     = $clog2(MAXBEATS + 1);
  localparam int HI       = (1 << (ACCW - 1)) - 1;
  localparam int LO       = -(1 << (ACCW - 1));

  logic                   clk_i;
  logic                   rst_ni;
  logic [LANES*DATAW-1:0] data_i;
  logic                   valid_i;
  logic                   last_i;
  logic                   ready_o;
  logic [LANES*ACCW-1:0]  sum_o;
  logic [CNTW-1:0]        beats_o;
  logic                   valid_o;
  logic                   ready_i;
`ifdef SAT_ACCUM_LANES_OVF_FLAG_EN
  logic [LANES-1:0]       ovf_o;
`endif

  sat_accum_lanes #(
    .DATAW   (DATAW),
    .ACCW    (ACCW),
    .LANES   (LANES),
    .MAXBEATS(MAXBEATS)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .data_i (data_i),
    .valid_i(valid_i),
    .last_i (last_i),
    .ready_o(ready_o),
    .sum_o  (sum_o),
    .beats_o(beats_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
`ifdef SAT_ACCUM_LANES_OVF_FLAG_EN
    ,
    .ovf_o  (ovf_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [LANES*ACCW-1:0] sum;
    int                    beats;
    logic [LANES-1:0]      ovf;
  } exp_t;

  exp_t exp_q[$];
  int   acc_m[LANES];
  bit   ovf_m[LANES];
  int   cnt_m;
  bit   expect_new;
  int   assert_count;
  int   fail_count;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [LANES*DATAW-1:0] pack4(input int a, input int b, input int c,
                                                   input int d);
    logic [LANES*DATAW-1:0] v;
    logic [31:0] ta, tb, tc, td;
    ta = a; tb = b; tc = c; td = d;
    v = {td[DATAW-1:0], tc[DATAW-1:0], tb[DATAW-1:0], ta[DATAW-1:0]};
    return v;
  endfunction

  // Drive one beat and hold it until the DUT takes it (bounded wait).
  task automatic applyStimulus(input logic [LANES*DATAW-1:0] data, input logic last);
    bit done;
    done    = 0;
    valid_i = 1'b1;
    data_i  = data;
    last_i  = last;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      if (ready_o) done = 1;
      @(posedge clk_i);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  // Scoreboard: check the output side first, then model any accepted beat.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
      for (int k = 0; k < LANES; k++) begin
        acc_m[k] = 0;
        ovf_m[k] = 0;
      end
      cnt_m      = 0;
      expect_new = 0;
    end else begin
      exp_t e;
      int   s;
      bit   o;
      bit   is_close;
      logic signed [DATAW-1:0] d;
      logic [31:0] sv;
      checkOutput("ready_o", 64'(ready_o), 64'(!valid_o || ready_i));
      if (expect_new) checkOutput("latency_valid", 64'(valid_o), 64'd1);
      expect_new = 0;
      if (valid_o) begin
        checkOutput("result_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          checkOutput("sum_o", 64'(sum_o), 64'(exp_q[0].sum));
          checkOutput("beats_o", 64'(beats_o), 64'(exp_q[0].beats));
`ifdef SAT_ACCUM_LANES_OVF_FLAG_EN
          checkOutput("ovf_o", 64'(ovf_o), 64'(exp_q[0].ovf));
`endif
          if (ready_i) void'(exp_q.pop_front());
        end
      end
      if (valid_i && ready_o) begin
        is_close = last_i || (cnt_m + 1 == MAXBEATS);
        e.sum    = '0;
        e.ovf    = '0;
        e.beats  = cnt_m + 1;
        for (int k = 0; k < LANES; k++) begin
          d = data_i[k*DATAW +: DATAW];
          s = acc_m[k] + int'(d);
          o = 0;
          if (s > HI) begin
            s = HI;
            o = 1;
          end else if (s < LO) begin
            s = LO;
            o = 1;
          end
          sv = s;
          if (is_close) begin
            e.sum[k*ACCW +: ACCW] = sv[ACCW-1:0];
            e.ovf[k] = ovf_m[k] | o;
            acc_m[k] = 0;
            ovf_m[k] = 0;
          end else begin
            acc_m[k] = s;
            ovf_m[k] = ovf_m[k] | o;
          end
        end
        if (is_close) begin
          exp_q.push_back(e);
          cnt_m      = 0;
          expect_new = 1;
        end else begin
          cnt_m++;
        end
      end
    end
  end

  initial begin
    assert_count = 0;
    fail_count   = 0;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = '0;
    ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_sum", 64'(sum_o), 64'd0);
    checkOutput("reset_beats", 64'(beats_o), 64'd0);
    checkOutput("reset_valid", 64'(valid_o), 64'd0);
    checkOutput("reset_ready", 64'(ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    rst_ni  = 1'b1;
    ready_i = 1'b1;

    $display("[TB] near-positive clamp");
    applyStimulus(pack4(124, 0, 0, 0), 1'b0);
    applyStimulus(pack4(3, 0, 0, 0), 1'b1);
    applyStimulus(pack4(124, 0, 0, 0), 1'b0);
    applyStimulus(pack4(4, 0, 0, 0), 1'b1);

    $display("[TB] negative clamp and single-beat packet");
    applyStimulus(pack4(-127, 0, 0, 0), 1'b0);
    applyStimulus(pack4(-1, 0, 0, 0), 1'b0);
    applyStimulus(pack4(-2, 0, 0, 0), 1'b1);
    applyStimulus(pack4(5, 0, 0, 0), 1'b1);

    $display("[TB] four independent lanes");
    applyStimulus(pack4(1, 2, -8, 0), 1'b0);
    applyStimulus(pack4(2, 2, 8, -128), 1'b1);

    $display("[TB] back-pressure hold then accept with new close");
    repeat (2) @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    applyStimulus(pack4(7, -7, 70, -70), 1'b1);
    valid_i = 1'b1;
    last_i  = 1'b0;
    data_i  = pack4(50, 50, 50, 50);
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("bp_ready_low", 64'(ready_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
    ready_i = 1'b1;
    last_i  = 1'b1;
    data_i  = pack4(9, 10, 11, 12);
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
    @(negedge clk_i);
    checkOutput("bp_no_bubble", 64'(valid_o), 64'd1);

    $display("[TB] beat limit closes packet");
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 6; i++) applyStimulus(pack4(1, 1, 1, 1), 1'b0);
    applyStimulus(pack4(1, 1, 1, 1), 1'b1);

    $display("[TB] reset mid-packet");
    for (int i = 0; i < 3; i++) applyStimulus(pack4(10, 10, 10, 10), 1'b0);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(valid_o), 64'd0);
    checkOutput("midrst_sum", 64'(sum_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    applyStimulus(pack4(1, 1, 1, 1), 1'b1);

    $display("[TB] random packets");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(pack4($urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 255)),
                    1'($urandom_range(0, 3) == 0));
    end
    applyStimulus(pack4(-1, -1, -1, -1), 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_i);
    repeat (2) @(posedge clk_i);
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
